bit_iter_64b: RTL and testbench

Serialises a 64-bit bitmap into a stream of 6-bit set-bit indices, one per cycle, highest index first.
- Sits directly upstream of and around enc_64b: holds the live mask, feeds it to an enc_64b instance, consumes the encoded index, then clears that bit.
- Used for request-vector scheduling and free-list walking, with valid/ready handshakes on both sides.

---
 rtl/bit_iter_64b_pkg.sv | 20 ++
 rtl/bit_iter_64b_enc.sv | 52 +++++
 rtl/bit_iter_64b.sv | 108 ++++++++++
 tb/tb_bit_iter_64b.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bit_iter_64b_pkg.sv
// Shared types and helpers for the bitmap-to-index iterator.
package bit_iter_pkg;

  localparam int BM_W  = 64;
  localparam int IDX_W = 6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bit_iter_state_t;

  // One-hot word with only bit idx set; used to clear the bit just emitted.
  function automatic logic [BM_W-1:0] onehot64(input logic [IDX_W-1:0] idx);
    logic [BM_W-1:0] w;
    w = '0;
    w[idx] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/bit_iter_64b_enc.sv
// enc_64b: highest-set-bit encoder for a 64-bit word, optionally registered.
// With REG_OUT=0 the index is purely combinational and clk/reset are unused.
module enc_64b
  import bit_iter_pkg::*;
#(
  parameter bit REG_OUT = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [BM_W-1:0]  in_data_i,
  input  logic             in_valid_i,
  output logic [IDX_W-1:0] out_idx_o,
  output logic             out_valid_o
);

  logic [IDX_W-1:0] w_idx;

  // Priority encode; later (higher) set bits overwrite lower ones, zero word gives 0.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < BM_W; i++) begin
      if (in_data_i[i]) w_idx = IDX_W'(i);
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [IDX_W-1:0] r_idx;
      logic             r_valid;

      // Register the encoded index and its valid.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          r_idx   <= '0;
          r_valid <= 1'b0;
        end else begin
          r_idx   <= w_idx;
          r_valid <= in_valid_i;
        end
      end

      assign out_idx_o   = r_idx;
      assign out_valid_o = r_valid;
    end else begin : g_comb
      logic w_clk_rst_unused;
      assign w_clk_rst_unused = clk_i ^ rst_n_i;
      assign out_idx_o   = w_idx;
      assign out_valid_o = in_valid_i;
    end
  endgenerate

endmodule

// File: rtl/bit_iter_64b.sv
// bit_iter_64b: walks a 64-bit bitmap and emits the index of each set bit,
// highest first, one beat per cycle.
//
// Handshake: a transfer happens on a side only in a cycle where both valid
// and ready are high at the rising edge. out_valid_o comes from state only;
// in_ready_o also rises when the final beat of the current word is taken, so
// it depends combinationally on out_ready_i and must not be looped back.
module bit_iter_64b
  import bit_iter_pkg::*;
#(
  parameter bit DROP_ZERO = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [BM_W-1:0]  in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [IDX_W-1:0] out_data_o,
  output logic             out_last_o,
  output logic             out_null_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output bit_iter_state_t  dbg_state_o
);

  bit_iter_state_t  r_state;
  logic [BM_W-1:0]  r_mask;
  logic             r_null;

  logic [IDX_W-1:0] w_idx;
  logic             w_enc_valid_unused;
  logic [BM_W-1:0]  w_rest;
  logic             w_last;
  logic             w_busy;
  logic             w_out_fire;
  logic             w_in_fire;
  logic             w_word_zero;

  enc_64b #(
    .REG_OUT (1'b0)
  ) u_enc (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_data_i   (r_mask),
    .in_valid_i  (1'b1),
    .out_idx_o   (w_idx),
    .out_valid_o (w_enc_valid_unused)
  );

  assign w_busy      = (r_state == BUSY);
  assign w_rest      = r_mask & ~onehot64(w_idx);
  assign w_last      = (w_rest == '0) | r_null;
  assign w_out_fire  = w_busy & out_ready_i;
  assign w_in_fire   = in_valid_i & in_ready_o;
  assign w_word_zero = (in_data_i == '0);

  assign out_valid_o = w_busy;
  assign out_data_o  = r_null ? '0 : w_idx;
  assign out_last_o  = w_busy & w_last;
  assign out_null_o  = r_null;
  assign in_ready_o  = ~w_busy | (w_out_fire & w_last);
  assign dbg_state_o = r_state;

  // Word load / bit-clear FSM; a finishing word can be replaced in the same cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_null  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_fire) begin
            if (!w_word_zero) begin
              r_mask  <= in_data_i;
              r_state <= BUSY;
            end else if (!DROP_ZERO) begin
              r_null  <= 1'b1;
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (w_out_fire) begin
            if (!w_last) begin
              r_mask <= w_rest;
            end else begin
              r_mask  <= '0;
              r_null  <= 1'b0;
              r_state <= IDLE;
              if (w_in_fire) begin
                if (!w_word_zero) begin
                  r_mask  <= in_data_i;
                  r_state <= BUSY;
                end else if (!DROP_ZERO) begin
                  r_null  <= 1'b1;
                  r_state <= BUSY;
                end
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_iter_64b.sv
// Bench for bit_iter_64b: two instances (zero words dropped / kept) share the
// input stimulus; each has its own expected-beat queue and monitor.
module tb_bit_iter_64b;
  import bit_iter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        d1_in_ready, d1_last, d1_null, d1_valid;
  logic [5:0]  d1_data;
  bit_iter_state_t d1_state;
  logic        d0_in_ready, d0_last, d0_null, d0_valid;
  logic [5:0]  d0_data;
  bit_iter_state_t d0_state;

  bit_iter_64b #(.DROP_ZERO(1'b1)) u_dut_drop (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(d1_in_ready),
    .out_data_o(d1_data), .out_last_o(d1_last), .out_null_o(d1_null),
    .out_valid_o(d1_valid), .out_ready_i(out_ready), .dbg_state_o(d1_state)
  );

  bit_iter_64b #(.DROP_ZERO(1'b0)) u_dut_keep (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(d0_in_ready),
    .out_data_o(d0_data), .out_last_o(d0_last), .out_null_o(d0_null),
    .out_valid_o(d0_valid), .out_ready_i(out_ready), .dbg_state_o(d0_state)
  );

  // ---------------- scoreboard ----------------
  // Beat encoding: {null, last, index[5:0]}.
  logic [7:0]  exp_q1[$];
  logic [7:0]  exp_q0[$];
  int unsigned fire_cyc[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hand-expanded expectations for one word: every set bit, descending.
  task automatic push_word(input logic [63:0] w);
    int cnt;
    int seen;
    if (w == 64'd0) begin
      exp_q0.push_back({1'b1, 1'b1, 6'd0});
      return;
    end
    cnt  = $countones(w);
    seen = 0;
    for (int i = 63; i >= 0; i--) begin
      if (w[i]) begin
        seen++;
        exp_q1.push_back({1'b0, seen == cnt, 6'(i)});
        exp_q0.push_back({1'b0, seen == cnt, 6'(i)});
      end
    end
  endtask

  // ---------------- monitors ----------------
  logic       hold_vld1 = 1'b0, hold_vld0 = 1'b0;
  logic [7:0] hold1, hold0;

  always @(negedge clk) begin
    logic [7:0] act;
    act = {d1_null, d1_last, d1_data};
    if (!rst_n) begin
      hold_vld1 = 1'b0;
    end else begin
      if (hold_vld1 && d1_valid) check("drop_hold_stable", {56'd0, act}, {56'd0, hold1});
      if (d1_valid && out_ready) begin
        fire_cyc.push_back(cyc);
        if (exp_q1.size() == 0) check("drop_unexpected_beat", {56'd0, act}, 64'hFFFF);
        else check("drop_beat", {56'd0, act}, {56'd0, exp_q1.pop_front()});
      end
      hold_vld1 = d1_valid && !out_ready;
      hold1     = act;
    end
  end

  always @(negedge clk) begin
    logic [7:0] act;
    act = {d0_null, d0_last, d0_data};
    if (!rst_n) begin
      hold_vld0 = 1'b0;
    end else begin
      if (hold_vld0 && d0_valid) check("keep_hold_stable", {56'd0, act}, {56'd0, hold0});
      if (d0_valid && out_ready) begin
        if (exp_q0.size() == 0) check("keep_unexpected_beat", {56'd0, act}, 64'hFFFF);
        else check("keep_beat", {56'd0, act}, {56'd0, exp_q0.pop_front()});
      end
      hold_vld0 = d0_valid && !out_ready;
      hold0     = act;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_word(input logic [63:0] w);
    int n;
    in_data  = w;
    in_valid = 1'b1;
    push_word(w);
    n = 0;
    while (!d1_in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((d1_valid || d0_valid || exp_q1.size() != 0 || exp_q0.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) check("idle_timeout", 64'd0, 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    #3;
    check("rst_valid", {63'd0, d1_valid}, 64'd0);
    check("rst_data", {58'd0, d1_data}, 64'd0);
    check("rst_last", {63'd0, d1_last}, 64'd0);
    check("rst_null", {63'd0, d1_null}, 64'd0);
    check("rst_in_ready", {63'd0, d1_in_ready}, 64'd1);
    check("rst_state", {63'd0, d1_state}, {63'd0, IDLE});
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two extreme bits, consecutive beats; in_ready high on the last beat.
    out_ready = 1'b1;
    fire_cyc.delete();
    send_word(64'h8000_0000_0000_0001);
    check("t1_first_idx", {58'd0, d1_data}, 64'd63);
    check("t1_in_ready_busy", {63'd0, d1_in_ready}, 64'd0);
    @(posedge clk); #1;
    check("t1_last_flag", {63'd0, d1_last}, 64'd1);
    check("t1_in_ready_last", {63'd0, d1_in_ready}, 64'd1);
    wait_idle();
    check("t1_beats", 64'(fire_cyc.size()), 64'd2);
    if (fire_cyc.size() == 2) check("t1_gap", 64'(fire_cyc[1] - fire_cyc[0]), 64'd1);

    // All ones: 64 beats; in_data changes while busy must be ignored.
    send_word(64'hFFFF_FFFF_FFFF_FFFF);
    in_data = 64'h0123_4567_89AB_CDEF;
    n = 0;
    while (!d1_in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("t2_ready_low_cycles", 64'(n), 64'd63);
    wait_idle();

    // Back-to-back words with no bubble between them.
    fire_cyc.delete();
    send_word(64'h0000_0000_0000_0030);
    send_word(64'h0000_0000_0000_0004);
    wait_idle();
    check("t3_beats", 64'(fire_cyc.size()), 64'd3);
    if (fire_cyc.size() == 3) check("t3_span", 64'(fire_cyc[2] - fire_cyc[0]), 64'd2);

    // Zero word: dropped by one instance, a null beat from the other.
    send_word(64'd0);
    check("t4_drop_valid", {63'd0, d1_valid}, 64'd0);
    check("t4_drop_in_ready", {63'd0, d1_in_ready}, 64'd1);
    check("t4_keep_valid", {63'd0, d0_valid}, 64'd1);
    check("t4_keep_null", {63'd0, d0_null}, 64'd1);
    check("t4_keep_last", {63'd0, d0_last}, 64'd1);
    check("t4_keep_data", {58'd0, d0_data}, 64'd0);
    @(posedge clk); #1;
    check("t4_keep_done", {63'd0, d0_valid}, 64'd0);
    wait_idle();

    // Backpressure: index 40 held for 5 cycles, then 40, 4.
    out_ready = 1'b0;
    send_word(64'h0000_0100_0000_0010);
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", {63'd0, d1_valid}, 64'd1);
      check("t5_hold_data", {58'd0, d1_data}, 64'd40);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle();

    // Reset mid-word: remaining bits dropped, then a fresh single-bit word.
    send_word(64'h0000_0000_0000_00F0);
    @(posedge clk); #1;
    #1;
    rst_n = 1'b0;
    exp_q1.delete();
    exp_q0.delete();
    #1;
    check("t6_rst_valid", {63'd0, d1_valid}, 64'd0);
    check("t6_rst_in_ready", {63'd0, d1_in_ready}, 64'd1);
    check("t6_rst_state", {63'd0, d1_state}, {63'd0, IDLE});
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_no_stale", {63'd0, d1_valid | d0_valid}, 64'd0);
    send_word(64'h0000_0000_0000_0001);
    check("t6_new_last", {63'd0, d1_last}, 64'd1);
    wait_idle();

    check("end_q1_empty", 64'(exp_q1.size()), 64'd0);
    check("end_q0_empty", 64'(exp_q0.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
